// File: rtl/reg_file_if.sv
// Operand-store bus: one write port and two read ports of the 8x16 register file.
// Latency: writes take effect at the clock edge; reads are combinational.
// Backpressure: none; every write is accepted and every read is served each cycle.
interface reg_file_if;
    logic        wr;
    logic [0:2]  wr_addr;
    logic [0:15] d_in;
    logic [0:2]  rd_addr_a;
    logic [0:2]  rd_addr_b;
    logic [0:15] d_out_a;
    logic [0:15] d_out_b;

    // ALU side: issues writes and read addresses, consumes operands
    modport master (
        output wr,
        output wr_addr,
        output d_in,
        output rd_addr_a,
        output rd_addr_b,
        input  d_out_a,
        input  d_out_b
    );

    // Register file side
    modport slave (
        input  wr,
        input  wr_addr,
        input  d_in,
        input  rd_addr_a,
        input  rd_addr_b,
        output d_out_a,
        output d_out_b
    );
endinterface

// File: rtl/reg_file.sv
// 8-entry x 16-bit register file, one write port, two independent read ports.
// Latency: write visible on reads the cycle after the edge; reads are 0-cycle combinational.
// Backpressure: none; writes never stall and there is no write-to-read bypass.
module reg_file (
    input  logic          clk,
    input  logic          reset,
    reg_file_if.slave     bus
);

    // R0..R7; bit 0 of each entry is the MSB, matching the bus bit order.
    logic [0:15] regs [0:7];

    // Per-register load strobes: one-hot when wr=1, all-zero when wr=0.
    logic [7:0] load;

    // Per-bit read selection over the eight registers.
    function automatic logic mux8(input logic [7:0] col, input logic [0:2] sel);
        return col[sel];
    endfunction

    // Write steering: the write enable is routed to the addressed register only.
    // Gating with wr first keeps an unknown address from producing a strobe while idle.
    always_comb begin
        load = '0;
        for (int i = 0; i < 8; i++) begin
            load[i] = bus.wr && (bus.wr_addr == 3'(i));
        end
    end

    // Storage update: synchronous reset clears everything and overrides any write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (load[i]) begin
                    regs[i] <= bus.d_in;
                end
            end
        end
    end

    logic [0:15] out_a;
    logic [0:15] out_b;
    logic [7:0]  col;

    // Read path: for every bit position, gather that bit from R0..R7 and select it
    // independently for each port; purely combinational from stored state.
    always_comb begin
        out_a = '0;
        out_b = '0;
        col   = '0;
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 8; i++) begin
                col[i] = regs[i][k];
            end
            out_a[k] = mux8(col, bus.rd_addr_a);
            out_b[k] = mux8(col, bus.rd_addr_b);
        end
    end

    assign bus.d_out_a = out_a;
    assign bus.d_out_b = out_b;

endmodule

// File: tb/tb_reg_file.sv
// Scoreboarded bench for reg_file: directed scenarios followed by random traffic.
// Latency: expected read data is queued per cycle and compared at the falling edge.
// Backpressure: not applicable; one expectation is queued and consumed per cycle.
module tb_reg_file;

    logic clk;
    logic reset;
    reg_file_if bus();

    reg_file dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  ra;
        logic [2:0]  rb;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] model [8];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    bit          drv_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // One clock of stimulus. The expected read data is what the model holds now,
    // i.e. before this cycle's edge (no bypass). After the edge the model applies
    // the register rules: reset clears all, else a write replaces one entry.
    task automatic drive(input logic rst, input logic w, input logic [2:0] wa,
                         input logic [15:0] din, input logic [2:0] ra,
                         input logic [2:0] rb, input bit chk);
        exp_t e;
        reset         = rst;
        bus.wr        = w;
        bus.wr_addr   = wa;
        bus.d_in      = din;
        bus.rd_addr_a = ra;
        bus.rd_addr_b = rb;
        if (chk) begin
            e.a   = model[ra];
            e.b   = model[rb];
            e.ra  = ra;
            e.rb  = rb;
            e.cyc = cyc;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (rst) begin
            for (int i = 0; i < 8; i++) model[i] = 16'h0000;
        end else if (w) begin
            model[wa] = din;
        end
    endtask

    task automatic sweep();
        for (int n = 0; n < 8; n++) begin
            drive(1'b0, 1'b0, 3'd0, 16'h0000, 3'(n), 3'(7 - n), 1'b1);
        end
    endtask

    // Monitor: consumes one expectation per cycle, away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (bus.d_out_a !== e.a) begin
                    failures++;
                    $display("FAIL port_a cyc=%0d addr=%0d got=%h exp=%h", e.cyc, e.ra, bus.d_out_a, e.a);
                end
                checks++;
                if (bus.d_out_b !== e.b) begin
                    failures++;
                    $display("FAIL port_b cyc=%0d addr=%0d got=%h exp=%h", e.cyc, e.rb, bus.d_out_b, e.b);
                end
            end
        end
    end

    initial begin
        logic [2:0] xaddr;
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
        xaddr = 3'bxxx;

        // Initial reset; contents are undefined before it, so nothing is checked yet.
        drive(1'b1, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 1'b0);
        // Reset state on every address
        sweep();

        // Reset clear after filling with ones
        for (int n = 0; n < 8; n++) drive(1'b0, 1'b1, 3'(n), 16'hFFFF, 3'(n), 3'(n), 1'b1);
        sweep();
        drive(1'b1, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd7, 1'b1);
        sweep();

        // Write/read all, A ascending and B descending
        for (int n = 0; n < 7; n++) drive(1'b0, 1'b1, 3'(n), 16'(16'h1111 * (n + 1)), 3'd0, 3'd7, 1'b1);
        drive(1'b0, 1'b1, 3'd7, 16'hA5A5, 3'd0, 3'd7, 1'b1);
        sweep();

        // Read during write: old value this cycle, new value next cycle
        drive(1'b0, 1'b1, 3'd3, 16'h00FF, 3'd3, 3'd3, 1'b1);
        drive(1'b0, 1'b1, 3'd3, 16'hBEEF, 3'd3, 3'd0, 1'b1);
        drive(1'b0, 1'b0, 3'd3, 16'h0000, 3'd3, 3'd3, 1'b1);

        // Write-enable gating, including an unknown address while idle
        for (int c = 0; c < 4; c++) drive(1'b0, 1'b0, 3'd5, 16'h1234, 3'd5, 3'(c), 1'b1);
        drive(1'b0, 1'b0, xaddr, 16'h5678, 3'd5, 3'd2, 1'b1);
        sweep();

        // Reset beats a simultaneous write; the repeated write then lands
        drive(1'b1, 1'b1, 3'd2, 16'hCAFE, 3'd2, 3'd6, 1'b1);
        drive(1'b0, 1'b1, 3'd2, 16'hCAFE, 3'd2, 3'd6, 1'b1);
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 3'd2, 3'd6, 1'b1);

        // Walking one per address, then read everything back
        for (int n = 0; n < 8; n++) drive(1'b0, 1'b1, 3'(n), 16'h8000 >> n, 3'(n), 3'd0, 1'b1);
        sweep();

        // Back-to-back writes to one address: each value visible for one cycle
        drive(1'b0, 1'b1, 3'd4, 16'h0001, 3'd4, 3'd4, 1'b1);
        drive(1'b0, 1'b1, 3'd4, 16'h0002, 3'd4, 3'd4, 1'b1);
        drive(1'b0, 1'b1, 3'd4, 16'h0003, 3'd4, 3'd4, 1'b1);
        drive(1'b0, 1'b0, 3'd4, 16'h0000, 3'd4, 3'd4, 1'b1);

        // Random traffic with occasional reset bursts
        for (int c = 0; c < 600; c++) begin
            drive(($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 7)), 16'($urandom),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 1'b1);
        end
        drive(1'b0, 1'b0, 3'd0, 16'h0000, 3'd0, 3'd0, 1'b0);
        drv_done = 1'b1;
    end

    // Drain the scoreboard within a bounded number of cycles, then report.
    initial begin
        int budget;
        budget = 20000;
        while (!drv_done && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        repeat (4) @(negedge clk);
        checks++;
        if (!drv_done || sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain done=%0d pending=%0d required_pending=0", drv_done, sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
